// File: rtl/mmio_responder.sv
// MMIO target servicing the bit-31 window: UART TX/RX holding registers plus cycle and
// retired-instruction counters. Define MMIO_BRANCH_CNT_EN to add branch counters at 0x1C/0x20.
`timescale 1ns/1ps
module mmio_responder #(
    parameter logic [31:0] CLOCK_FREQ = 32'd50_000_000,
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    input  logic        branch_valid,
    input  logic        branch_correct
);

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_RX   = 4'h1;
    localparam logic [3:0] OFF_TX   = 4'h2;
    localparam logic [3:0] OFF_CYC  = 4'h4;
    localparam logic [3:0] OFF_INST = 4'h5;
    localparam logic [3:0] OFF_CLR  = 4'h6;
    localparam logic [3:0] OFF_BR   = 4'h7;
    localparam logic [3:0] OFF_BROK = 4'h8;

    logic [3:0]  offset;
    logic        in_window;
    logic        rd_load;
    logic        wr_store;
    logic        tx_store;
    logic        tx_fire;
    logic        rx_capture;
    logic        rx_read;
    logic        cnt_clr;
    logic [31:0] rd_val;

    logic        tx_full_q, tx_full_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] inst_cnt_q, inst_cnt_d;
    logic [31:0] rdata_q, rdata_d;

    assign offset    = req_addr[5:2];
    assign in_window = (req_addr[31] == ADDR_BASE[31]);
    assign rd_load   = req_valid & in_window & ~req_wen;
    assign wr_store  = req_valid & in_window & req_wen;
    assign tx_store  = wr_store & (offset == OFF_TX);
    assign cnt_clr   = wr_store & (offset == OFF_CLR);

    // Both UART sides use valid/ready: a byte moves on any edge where valid & ready are high;
    // the sender holds data stable while valid is high, and valid never waits on ready.
    assign tx_fire    = tx_full_q & uart_tx_ready;
    assign rx_capture = uart_rx_valid & ~rx_full_q;
    assign rx_read    = rd_load & (offset == OFF_RX) & rx_full_q;

    assign uart_tx_valid = tx_full_q;
    assign uart_tx_data  = tx_byte_q;
    assign uart_rx_ready = ~rx_full_q;
    assign rdata         = rdata_q;

`ifdef MMIO_BRANCH_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] br_ok_cnt_q, br_ok_cnt_d;

    always_comb begin
        br_cnt_d    = br_cnt_q + {31'd0, branch_valid};
        br_ok_cnt_d = br_ok_cnt_q + {31'd0, branch_valid & branch_correct};
        if (cnt_clr) begin
            br_cnt_d    = '0;
            br_ok_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            br_ok_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            br_ok_cnt_q <= br_ok_cnt_d;
        end
    end
`endif

    // Load data reflects state as it stands in the request cycle, before this edge's updates.
    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_CTRL: rd_val = {30'd0, rx_full_q, ~tx_full_q};
            OFF_RX:   rd_val = {24'd0, rx_byte_q};
            OFF_CYC:  rd_val = cycle_cnt_q;
            OFF_INST: rd_val = inst_cnt_q;
`ifdef MMIO_BRANCH_CNT_EN
            OFF_BR:   rd_val = br_cnt_q;
            OFF_BROK: rd_val = br_ok_cnt_q;
`else
            OFF_BR:   rd_val = '0;
            OFF_BROK: rd_val = '0;
`endif
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        tx_full_d   = tx_full_q;
        tx_byte_d   = tx_byte_q;
        rx_full_d   = rx_full_q;
        rx_byte_d   = rx_byte_q;
        rdata_d     = rdata_q;
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        inst_cnt_d  = inst_cnt_q + {31'd0, inst_retire};

        // A store while the holding register is full is dropped, even if it drains this edge.
        if (tx_store && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_byte_d = req_wdata[7:0];
        end else if (tx_fire) begin
            tx_full_d = 1'b0;
        end

        if (rx_capture) begin
            rx_full_d = 1'b1;
            rx_byte_d = uart_rx_data;
        end else if (rx_read) begin
            rx_full_d = 1'b0;
        end

        if (cnt_clr) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end

        if (rd_load) begin
            rdata_d = rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full_q   <= 1'b0;
            tx_byte_q   <= '0;
            rx_full_q   <= 1'b0;
            rx_byte_q   <= '0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            rdata_q     <= '0;
        end else begin
            tx_full_q   <= tx_full_d;
            tx_byte_q   <= tx_byte_d;
            rx_full_q   <= rx_full_d;
            rx_byte_q   <= rx_byte_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    logic unused_ok;
`ifdef MMIO_BRANCH_CNT_EN
    assign unused_ok = ^{CLOCK_FREQ, req_addr[30:6], req_addr[1:0], req_wdata[31:8]};
`else
    assign unused_ok = ^{CLOCK_FREQ, req_addr[30:6], req_addr[1:0], req_wdata[31:8],
                         branch_valid, branch_correct};
`endif

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed test-plan sequences followed by randomized traffic,
// all checked against a register-level reference model of the MMIO window.
`timescale 1ns/1ps
module tb_mmio_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = BASE;
    logic [31:0] req_wdata = '0;
    logic [31:0] rdata;
    logic        inst_retire = 1'b0;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;
    logic        branch_valid = 1'b0;
    logic        branch_correct = 1'b0;

    mmio_responder #(.CLOCK_FREQ(32'd50_000_000), .ADDR_BASE(BASE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rdata         (rdata),
        .inst_retire   (inst_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .branch_valid  (branch_valid),
        .branch_correct(branch_correct)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    logic        m_tx_full;
    logic [7:0]  m_tx_byte;
    logic        m_rx_full;
    logic [7:0]  m_rx_byte;
    logic [31:0] m_cycle, m_inst, m_br, m_brok, m_rdata;
    int          n_tx_exp, n_tx_obs;
    logic [7:0]  last_tx_obs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tx_full = 1'b0;
        m_tx_byte = '0;
        m_rx_full = 1'b0;
        m_rx_byte = '0;
        m_cycle   = '0;
        m_inst    = '0;
        m_br      = '0;
        m_brok    = '0;
        m_rdata   = '0;
    endtask

    // Register file view of the window as software sees it.
    function automatic logic [31:0] model_read(input logic [3:0] off);
        logic [31:0] regs [16];
        foreach (regs[i]) regs[i] = '0;
        regs[0] = {30'd0, m_rx_full, !m_tx_full};
        regs[1] = {24'd0, m_rx_byte};
        regs[4] = m_cycle;
        regs[5] = m_inst;
`ifdef MMIO_BRANCH_CNT_EN
        regs[7] = m_br;
        regs[8] = m_brok;
`endif
        return regs[off];
    endfunction

    task automatic model_update(input logic [3:0] off);
        logic ld, st;
        ld = req_valid && !req_wen;
        st = req_valid && req_wen;
        if (st && off == 4'h2 && !m_tx_full) begin
            m_tx_full = 1'b1;
            m_tx_byte = req_wdata[7:0];
        end else if (m_tx_full && uart_tx_ready) begin
            m_tx_full = 1'b0;
            n_tx_exp++;
        end
        if (!m_rx_full && uart_rx_valid) begin
            m_rx_full = 1'b1;
            m_rx_byte = uart_rx_data;
        end else if (ld && off == 4'h1) begin
            m_rx_full = 1'b0;
        end
        if (st && off == 4'h6) begin
            m_cycle = '0;
            m_inst  = '0;
            m_br    = '0;
            m_brok  = '0;
        end else begin
            m_cycle = m_cycle + 1;
            m_inst  = m_inst + (inst_retire ? 1 : 0);
            m_br    = m_br + (branch_valid ? 1 : 0);
            m_brok  = m_brok + ((branch_valid && branch_correct) ? 1 : 0);
        end
    endtask

    // One clock: model the cycle from current inputs, let the edge pass, compare outputs.
    task automatic tick();
        logic [3:0] off;
        logic ld;
        off = req_addr[5:2];
        ld  = req_valid && !req_wen;
        if (ld) exp_q.push_back(model_read(off));
        if (uart_tx_valid && uart_tx_ready) begin
            n_tx_obs++;
            last_tx_obs = uart_tx_data;
        end
        model_update(off);
        @(posedge clk);
        #1;
        if (ld) m_rdata = exp_q.pop_front();
        check_eq("rdata", rdata, m_rdata);
        check_eq("tx_valid", {31'd0, uart_tx_valid}, {31'd0, m_tx_full});
        check_eq("tx_data", {24'd0, uart_tx_data}, {24'd0, m_tx_byte});
        check_eq("rx_ready", {31'd0, uart_rx_ready}, {31'd0, !m_rx_full});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_wdata = '0;
    endtask

    task automatic do_load(input logic [3:0] off);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = BASE | {26'd0, off, 2'b00};
        tick();
        drive_idle();
    endtask

    task automatic do_store(input logic [3:0] off, input logic [31:0] data);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = BASE | {26'd0, off, 2'b00};
        req_wdata = data;
        tick();
        drive_idle();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] offs [9];
        offs[0] = 4'h0; offs[1] = 4'h1; offs[2] = 4'h2; offs[3] = 4'h4; offs[4] = 4'h5;
        offs[5] = 4'h6; offs[6] = 4'h7; offs[7] = 4'h8; offs[8] = 4'h3;
        n_tx_exp = 0;
        n_tx_obs = 0;
        last_tx_obs = '0;

        apply_reset();
        check_eq("reset_rdata", rdata, 32'h0);
        check_eq("reset_tx_valid", {31'd0, uart_tx_valid}, 32'h0);
        check_eq("reset_tx_data", {24'd0, uart_tx_data}, 32'h0);
        check_eq("reset_rx_ready", {31'd0, uart_rx_ready}, 32'h1);
        do_load(4'h0);
        check_eq("ctrl_after_reset", rdata, 32'h1);

        // TX holding register: second store while full is dropped
        uart_tx_ready = 1'b0;
        do_store(4'h2, 32'hFFFF_FF41);
        check_eq("tx_loaded_valid", {31'd0, uart_tx_valid}, 32'h1);
        check_eq("tx_loaded_data", {24'd0, uart_tx_data}, 32'h41);
        do_store(4'h2, 32'h42);
        check_eq("tx_drop_data", {24'd0, uart_tx_data}, 32'h41);
        uart_tx_ready = 1'b1;
        tick();
        uart_tx_ready = 1'b0;
        check_eq("tx_drained_valid", {31'd0, uart_tx_valid}, 32'h0);
        tick();
        check_eq("tx_byte_count", n_tx_obs, 32'd1);
        check_eq("tx_byte_value", {24'd0, last_tx_obs}, 32'h41);

        // RX holding register
        uart_rx_data  = 8'h5A;
        uart_rx_valid = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        check_eq("rx_full_ready", {31'd0, uart_rx_ready}, 32'h0);
        do_load(4'h0);
        check_eq("rx_ctrl_full", rdata, 32'h3);
        do_load(4'h1);
        check_eq("rx_data", rdata, 32'h5A);
        do_load(4'h0);
        check_eq("rx_ctrl_empty", rdata, 32'h1);
        check_eq("rx_ready_again", {31'd0, uart_rx_ready}, 32'h1);
        do_load(4'h1);
        check_eq("rx_stale", rdata, 32'h5A);

        // Counters: 7 retires over 20 cycles, then clear
        for (int i = 0; i < 20; i++) begin
            inst_retire = (i % 3 == 0) && (i < 21);
            tick();
        end
        inst_retire = 1'b0;
        do_load(4'h5);
        check_eq("inst_cnt_7", rdata, 32'd7);
        do_store(4'h6, 32'hDEAD_BEEF);
        tick();
        do_load(4'h4);
        check_eq("cycle_after_clear", rdata, 32'd1);
        do_load(4'h5);
        check_eq("inst_after_clear", rdata, 32'd0);

        // Wrap of cycle_cnt through a deposited value
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        m_cycle = 32'hFFFF_FFFF;
        do_load(4'h4);
        check_eq("cycle_at_max", rdata, 32'hFFFF_FFFF);
        do_load(4'h4);
        check_eq("cycle_wrapped", rdata, 32'h0);

        // Clear wins over a coincident increment
        inst_retire = 1'b1;
        tick();
        do_store(4'h6, 32'h0);
        inst_retire = 1'b0;
        do_load(4'h5);
        check_eq("clear_wins_inst", rdata, 32'h0);

        // Branch counters: 5 branches, 3 correct
        do_store(4'h6, 32'h0);
        for (int i = 0; i < 5; i++) begin
            branch_valid   = 1'b1;
            branch_correct = (i != 1) && (i != 3);
            tick();
        end
        branch_valid   = 1'b0;
        branch_correct = 1'b1;
        tick();
        do_load(4'h7);
`ifdef MMIO_BRANCH_CNT_EN
        check_eq("br_cnt", rdata, 32'd5);
`else
        check_eq("br_cnt", rdata, 32'd0);
`endif
        do_load(4'h8);
`ifdef MMIO_BRANCH_CNT_EN
        check_eq("br_ok_cnt", rdata, 32'd3);
`else
        check_eq("br_ok_cnt", rdata, 32'd0);
`endif
        branch_correct = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [3:0] off;
            off = offs[$urandom_range(0, 8)];
            if (off == 4'h6 && $urandom_range(0, 3) != 0) off = 4'h4;
            req_valid      = ($urandom_range(0, 1) == 1);
            req_wen        = ($urandom_range(0, 1) == 1);
            req_addr       = 32'h8000_0000 | ($urandom & 32'h7FFF_FFC3) | {26'd0, off, 2'b00};
            req_wdata      = $urandom;
            uart_tx_ready  = ($urandom_range(0, 3) == 0);
            uart_rx_valid  = ($urandom_range(0, 2) == 0);
            uart_rx_data   = 8'($urandom);
            inst_retire    = ($urandom_range(0, 1) == 1);
            branch_valid   = ($urandom_range(0, 1) == 1);
            branch_correct = ($urandom_range(0, 1) == 1);
            tick();
        end
        drive_idle();
        uart_rx_valid = 1'b0;
        inst_retire   = 1'b0;
        branch_valid  = 1'b0;
        check_eq("tx_handshakes", n_tx_obs, n_tx_exp);

        // Asynchronous reset with a byte pending
        uart_tx_ready = 1'b1;
        tick();
        uart_tx_ready = 1'b0;
        do_store(4'h2, 32'h77);
        check_eq("pre_reset_tx_valid", {31'd0, uart_tx_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_tx_valid", {31'd0, uart_tx_valid}, 32'h0);
        check_eq("async_reset_rdata", rdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_load(4'h0);
        check_eq("ctrl_after_async_reset", rdata, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
